tb4001_rom_responder: RTL
=========================

Name: tb4001_rom_responder

Overview:
- ROM-side responder on the 4004 multiplexed 4-bit bus; the other end of the CPU instruction fetch feeding the instruction decoder.
- Tracks the 8-cycle instruction frame (A1..X3) from the CPU sync strobe and latches the 12-bit address: low, mid, then chip nibble.
- When the chip nibble matches CHIP_ID, drives the fetched byte back: OPR in M1, OPA in M2.
- Holds a 256x8 program array, loadable through a synchronous program port.

Parameters:
- CHIP_ID, 4'h0, chip-select value compared against the A3 nibble.
- DEPTH_LOG2, 8, address width of the program array (fixed 256 words; other values unsupported).

Ports:
- clk  in  1  system clock
- rstN  in  1  asynchronous, active-low reset
- sync  in  1  CPU frame strobe; high during X3, so the next cycle is A1
- dataIn  in  4  resolved bus value (CPU-driven nibbles plus own echo)
- cmRom  in  1  CPU ROM command line (used only with the optional feature)
- dataOut  out  4  nibble driven onto the bus
- dataOe  out  1  bus drive enable for dataOut
- cycle  out  3  current frame cycle: A1=0, A2=1, A3=2, M1=3, M2=4, X1=5, X2=6, X3=7
- frameValid  out  1  high once locked to sync
- syncErr  out  1  one-clock pulse on an out-of-place sync
- progWe  in  1  program-array write strobe
- progAddr  in  8  program-array write address
- progData  in  8  program-array write data
- ioOut  out  4  I/O port output latch (optional feature)
- ioIn  in  4  I/O port input pins (optional feature)

Behaviour:
- Reset values: cycle=0, frameValid=0, dataOut=0, dataOe=0, syncErr=0, ioOut=0, address latches=0, selected=0. Array contents are not reset.
- Unlocked (frameValid=0):
  - cycle holds at 0 and dataOe stays 0.
  - The first sampled sync=1 sets frameValid=1 and cycle=0 (A1) on the following clock.
- Locked:
  - cycle increments every clock and wraps from 7 to 0.
  - sync=1 while cycle==7: normal, no effect.
  - sync=1 while cycle!=7: next cycle=0, syncErr pulses 1 for one clock, and the in-flight frame is abandoned (dataOe=0).
  - sync=0 at cycle==7: wrap proceeds and frameValid stays 1 (sync only checked, never required).
- Address capture, on the edge ending each cycle:
  - A1: addr[3:0]=dataIn.
  - A2: addr[7:4]=dataIn.
  - A3: selected=(dataIn==CHIP_ID).
- Data drive (registered):
  - On the edge ending A3: if selected, dataOut=mem[addr][7:4] and dataOe=1, held throughout M1.
  - On the edge ending M1: dataOut=mem[addr][3:0], held throughout M2.
  - On the edge ending M2: dataOe=0 and dataOut=0.
  - dataOe is never 1 outside M1/M2 unless the optional feature is enabled.
  - If not selected, dataOe stays 0 for the whole frame.
- Program port:
  - progWe writes mem[progAddr]=progData at the clock edge, in any cycle.
  - A write to the address being read on the same edge returns the old data (read-before-write).
- Reset asserted mid-frame: outputs return to reset values immediately (async); the block relocks on the next sync.

Optional Feature:
- Macro: TB4001_ROM_IO_PORT_EN.
- Enabled:
  - SRC: X2 with cmRom=1 latches srcSel=(dataIn==CHIP_ID).
  - M2 with cmRom=1 latches ioOp=dataIn (OPA of the I/O instruction).
  - X2 with ioOp==4'h2 (WRR) and srcSel: ioOut=dataIn on the edge ending X2.
  - X2 with ioOp==4'hA (RDR) and srcSel: dataOut=ioIn and dataOe=1 throughout X2, cleared entering X3.
  - ioOp is cleared at A1 of each frame.
- Disabled: cmRom and ioIn are ignored and ioOut is tied to 0. All other behaviour is identical.

Test Plan:
- Reset, then hold sync=0 for 20 clks -> frameValid=0, dataOe=0, cycle=0 throughout.
- mem[8'h5C]=8'hD7, CHIP_ID=0; sync, then bus nibbles C,5,0 in A1..A3 -> M1: dataOe=1, dataOut=D; M2: dataOut=7; X1: dataOe=0.
- Same frame with A3 nibble=1 -> dataOe=0 for all 8 cycles.
- sync asserted at cycle=3 -> syncErr=1 for one clk, next cycle=0, dataOe=0 in the abandoned frame.
- progWe to 8'h5C with data 8'h3A on the edge ending A3 of a fetch of 5C -> M1/M2 drive D/7; the next frame drives 3/A.
- TB4001_ROM_IO_PORT_EN: SRC with nibble 0 in X2 (cmRom=1), then an I/O frame with M2 OPA=2 and X2 bus=9 -> ioOut=9. Repeat with OPA=A and ioIn=6 -> X2 dataOut=6, dataOe=1.

Source files
------------

// File: rtl/tb4001_rom_responder.sv
// ROM-side responder for the 4004 multiplexed bus: frame tracking, address capture, opcode return.
// Optional I/O port (SRC/WRR/RDR) is built when TB4001_ROM_IO_PORT_EN is defined.
module tb4001_rom_responder #(
  parameter logic [3:0]  CHIP_ID    = 4'h0,
  parameter int unsigned DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  sync,
  input  logic [3:0]            dataIn,
  input  logic                  cmRom,
  output logic [3:0]            dataOut,
  output logic                  dataOe,
  output logic [2:0]            cycle,
  output logic                  frameValid,
  output logic                  syncErr,
  input  logic                  progWe,
  input  logic [DEPTH_LOG2-1:0] progAddr,
  input  logic [7:0]            progData,
  output logic [3:0]            ioOut,
  input  logic [3:0]            ioIn
);

  typedef enum logic [2:0] {
    CYC_A1 = 3'd0, CYC_A2 = 3'd1, CYC_A3 = 3'd2, CYC_M1 = 3'd3,
    CYC_M2 = 3'd4, CYC_X1 = 3'd5, CYC_X2 = 3'd6, CYC_X3 = 3'd7
  } cycle_e;

  cycle_e                cycle_q, cycle_d;
  logic                  frame_valid_q, frame_valid_d;
  logic                  sync_err_q, sync_err_d;
  logic                  selected_q, selected_d;
  logic                  data_oe_q, data_oe_d;
  logic [3:0]            data_out_q, data_out_d;
  logic [3:0]            rd_lo_q, rd_lo_d;
  logic [DEPTH_LOG2-1:0] addr_q, addr_d;
  logic [7:0]            mem_q [0:(1<<DEPTH_LOG2)-1];
  logic [7:0]            rd_byte;
  logic                  chip_hit;
`ifdef TB4001_ROM_IO_PORT_EN
  logic                  src_sel_q, src_sel_d;
  logic [3:0]            io_op_q, io_op_d;
  logic [3:0]            io_out_q, io_out_d;
`endif

  always_comb begin
    cycle_d       = cycle_q;
    frame_valid_d = frame_valid_q;
    sync_err_d    = 1'b0;
    selected_d    = selected_q;
    data_oe_d     = data_oe_q;
    data_out_d    = data_out_q;
    rd_lo_d       = rd_lo_q;
    addr_d        = addr_q;
    rd_byte       = mem_q[addr_q];
    chip_hit      = (dataIn == CHIP_ID);
`ifdef TB4001_ROM_IO_PORT_EN
    src_sel_d     = src_sel_q;
    io_op_d       = io_op_q;
    io_out_d      = io_out_q;
`endif
    if (!frame_valid_q) begin
      cycle_d = CYC_A1;
      if (sync) frame_valid_d = 1'b1;
    end else if (sync && cycle_q != CYC_X3) begin
      cycle_d    = CYC_A1;
      sync_err_d = 1'b1;
      data_oe_d  = 1'b0;
      data_out_d = '0;
      selected_d = 1'b0;
`ifdef TB4001_ROM_IO_PORT_EN
      io_op_d    = '0;
`endif
    end else begin
      cycle_d = cycle_e'(cycle_q + 3'd1);
      case (cycle_q)
        CYC_A1: begin
          addr_d = {addr_q[7:4], dataIn};
`ifdef TB4001_ROM_IO_PORT_EN
          io_op_d = '0;
`endif
        end
        CYC_A2: addr_d = {dataIn, addr_q[3:0]};
        CYC_A3: begin
          // Whole byte is sampled here so a program write landing on this edge
          // cannot split the returned opcode between old and new data.
          selected_d = chip_hit;
          rd_lo_d    = rd_byte[3:0];
          if (chip_hit) begin
            data_out_d = rd_byte[7:4];
            data_oe_d  = 1'b1;
          end
        end
        CYC_M1: if (selected_q) data_out_d = rd_lo_q;
        CYC_M2: begin
          data_oe_d  = 1'b0;
          data_out_d = '0;
`ifdef TB4001_ROM_IO_PORT_EN
          if (cmRom) io_op_d = dataIn;
`endif
        end
`ifdef TB4001_ROM_IO_PORT_EN
        CYC_X1: if (io_op_q == 4'hA && src_sel_q) begin
          data_out_d = ioIn;
          data_oe_d  = 1'b1;
        end
        CYC_X2: begin
          data_oe_d  = 1'b0;
          data_out_d = '0;
          if (io_op_q == 4'h2 && src_sel_q) io_out_d = dataIn;
          if (cmRom) src_sel_d = chip_hit;
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      cycle_q       <= CYC_A1;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
      selected_q    <= 1'b0;
      data_oe_q     <= 1'b0;
      data_out_q    <= '0;
      rd_lo_q       <= '0;
      addr_q        <= '0;
`ifdef TB4001_ROM_IO_PORT_EN
      src_sel_q     <= 1'b0;
      io_op_q       <= '0;
      io_out_q      <= '0;
`endif
    end else begin
      cycle_q       <= cycle_d;
      frame_valid_q <= frame_valid_d;
      sync_err_q    <= sync_err_d;
      selected_q    <= selected_d;
      data_oe_q     <= data_oe_d;
      data_out_q    <= data_out_d;
      rd_lo_q       <= rd_lo_d;
      addr_q        <= addr_d;
`ifdef TB4001_ROM_IO_PORT_EN
      src_sel_q     <= src_sel_d;
      io_op_q       <= io_op_d;
      io_out_q      <= io_out_d;
`endif
    end
  end

  // Program array: no reset, plain synchronous write port.
  always_ff @(posedge clk) begin
    if (progWe) mem_q[progAddr] <= progData;
  end

  assign cycle      = cycle_q;
  assign frameValid = frame_valid_q;
  assign syncErr    = sync_err_q;
  assign dataOe     = data_oe_q;
  assign dataOut    = data_out_q;
`ifdef TB4001_ROM_IO_PORT_EN
  assign ioOut      = io_out_q;
`else
  logic unused_io;
  assign unused_io  = ^{cmRom, ioIn};
  assign ioOut      = '0;
`endif

endmodule
